// File: rtl/alu_result_encoder.sv
// -----------------------------------------------------------------------------
// alu_result_encoder
//
// Return path of the ALU. It collects the four unit results with their one-cycle
// valid strobes and encodes the single active unit into a 2-bit function code.
// It then queues {code, result} in a small FIFO that the system controller
// drains with a valid/ready handshake. All outputs come from flops, so there is
// no combinational path from the inputs to the outputs.
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   <Unit>_OUT, <Unit>_Valid unit result and strobe (Arith, Logic, CMP, Shift)
//   OUT_Ready                consumer accepts the head entry
//   Err_Clr                  clears the sticky error flags on the next edge
//   ALU_OUT, ALU_FUN_OUT     head entry result / function code (0 when empty)
//   OUT_Valid, Busy          FIFO non-empty / FIFO full
//   Collision_Err            sticky: more than one strobe in one cycle
//   Overflow_Err             sticky: a result was dropped on a full FIFO
// -----------------------------------------------------------------------------
module alu_result_encoder #(
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 2   // power of 2, >= 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [OUT_WIDTH-1:0] Arith_OUT,
    input  logic                 Arith_Valid,
    input  logic [OUT_WIDTH-1:0] Logic_OUT,
    input  logic                 Logic_Valid,
    input  logic [OUT_WIDTH-1:0] CMP_OUT,
    input  logic                 CMP_Valid,
    input  logic [OUT_WIDTH-1:0] Shift_OUT,
    input  logic                 Shift_Valid,
    input  logic                 OUT_Ready,
    input  logic                 Err_Clr,
    output logic [OUT_WIDTH-1:0] ALU_OUT,
    output logic [1:0]           ALU_FUN_OUT,
    output logic                 OUT_Valid,
    output logic                 Busy,
    output logic                 Collision_Err,
    output logic                 Overflow_Err
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    // Storage and control state
    logic [OUT_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [OUT_WIDTH-1:0] mem_data_d [FIFO_DEPTH];
    logic [1:0]           mem_code_q [FIFO_DEPTH];
    logic [1:0]           mem_code_d [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic [OUT_WIDTH-1:0] alu_out_q, alu_out_d;
    logic [1:0]           alu_fun_out_q, alu_fun_out_d;
    logic                 collision_err_q, collision_err_d;
    logic                 overflow_err_q, overflow_err_d;

    // Input encode
    logic [2:0]           n_valid;
    logic [1:0]           in_code;
    logic [OUT_WIDTH-1:0] in_data;
    logic                 push_req, collision, full, pop, push, overflow;

    assign n_valid = 3'(Arith_Valid) + 3'(Logic_Valid) + 3'(CMP_Valid) + 3'(Shift_Valid);

    // Only meaningful when exactly one strobe is high, so a simple priority
    // chain is enough; Arith is the fall-through default.
    always_comb begin
        in_code = 2'b00;
        in_data = Arith_OUT;
        if (Logic_Valid) begin
            in_code = 2'b01;
            in_data = Logic_OUT;
        end else if (CMP_Valid) begin
            in_code = 2'b10;
            in_data = CMP_OUT;
        end else if (Shift_Valid) begin
            in_code = 2'b11;
            in_data = Shift_OUT;
        end
    end

    assign push_req  = (n_valid == 3'd1);
    assign collision = (n_valid > 3'd1);
    assign full      = (count_q == DepthCnt);
    // out_valid_q mirrors count_q != 0, so Ready on an empty FIFO is ignored
    assign pop       = out_valid_q && OUT_Ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign push      = push_req && (!full || pop);
    assign overflow  = push_req && full && !pop;

    always_comb begin
        mem_data_d = mem_data_q;
        mem_code_d = mem_code_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = in_data;
            mem_code_d[wr_ptr_q] = in_code;
        end

        // Pointers wrap naturally since the depth is a power of two
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(push) - CntW'(pop);

        out_valid_d = (count_d != '0);
        busy_d      = (count_d == DepthCnt);

        // Head register is taken from the post-write storage so a push into an
        // empty FIFO (or into the slot right behind a popped head) is visible
        // one cycle after its strobe.
        if (count_d != '0) begin
            alu_out_d     = mem_data_d[rd_ptr_d];
            alu_fun_out_d = mem_code_d[rd_ptr_d];
        end else begin
            alu_out_d     = '0;
            alu_fun_out_d = 2'b00;
        end

        // A new event wins over a simultaneous clear
        collision_err_d = collision || (collision_err_q && !Err_Clr);
        overflow_err_d  = overflow || (overflow_err_q && !Err_Clr);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_data_q[i] <= '0;
                mem_code_q[i] <= 2'b00;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            out_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            alu_out_q       <= '0;
            alu_fun_out_q   <= 2'b00;
            collision_err_q <= 1'b0;
            overflow_err_q  <= 1'b0;
        end else begin
            mem_data_q      <= mem_data_d;
            mem_code_q      <= mem_code_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            out_valid_q     <= out_valid_d;
            busy_q          <= busy_d;
            alu_out_q       <= alu_out_d;
            alu_fun_out_q   <= alu_fun_out_d;
            collision_err_q <= collision_err_d;
            overflow_err_q  <= overflow_err_d;
        end
    end

    assign ALU_OUT       = alu_out_q;
    assign ALU_FUN_OUT   = alu_fun_out_q;
    assign OUT_Valid     = out_valid_q;
    assign Busy          = busy_q;
    assign Collision_Err = collision_err_q;
    assign Overflow_Err  = overflow_err_q;

endmodule

// File: tb/tb_alu_result_encoder.sv
// -----------------------------------------------------------------------------
// tb_alu_result_encoder
//
// Directed scenarios plus randomized traffic. Every cycle's outputs are compared
// against a queue-based reference model that is driven by the same inputs.
// -----------------------------------------------------------------------------
module tb_alu_result_encoder;

    localparam int unsigned W = 16;
    localparam int unsigned D = 2;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
    logic         Arith_Valid, Logic_Valid, CMP_Valid, Shift_Valid;
    logic         OUT_Ready, Err_Clr;
    logic [W-1:0] ALU_OUT;
    logic [1:0]   ALU_FUN_OUT;
    logic         OUT_Valid, Busy, Collision_Err, Overflow_Err;

    alu_result_encoder #(
        .OUT_WIDTH  (W),
        .FIFO_DEPTH (D)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .Arith_OUT     (Arith_OUT),
        .Arith_Valid   (Arith_Valid),
        .Logic_OUT     (Logic_OUT),
        .Logic_Valid   (Logic_Valid),
        .CMP_OUT       (CMP_OUT),
        .CMP_Valid     (CMP_Valid),
        .Shift_OUT     (Shift_OUT),
        .Shift_Valid   (Shift_Valid),
        .OUT_Ready     (OUT_Ready),
        .Err_Clr       (Err_Clr),
        .ALU_OUT       (ALU_OUT),
        .ALU_FUN_OUT   (ALU_FUN_OUT),
        .OUT_Valid     (OUT_Valid),
        .Busy          (Busy),
        .Collision_Err (Collision_Err),
        .Overflow_Err  (Overflow_Err)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: queue of {code, data}, plus the two sticky flags
    logic [17:0] mq[$];
    logic        m_coll = 1'b0;
    logic        m_ovf  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [17:0] head;
        head = (mq.size() != 0) ? mq[0] : 18'd0;
        check_eq({tag, " OUT_Valid"},     32'(OUT_Valid),     32'(mq.size() != 0));
        check_eq({tag, " Busy"},          32'(Busy),          32'(mq.size() == D));
        check_eq({tag, " ALU_OUT"},       32'(ALU_OUT),       32'(head[15:0]));
        check_eq({tag, " ALU_FUN_OUT"},   32'(ALU_FUN_OUT),   32'(head[17:16]));
        check_eq({tag, " Collision_Err"}, 32'(Collision_Err), 32'(m_coll));
        check_eq({tag, " Overflow_Err"},  32'(Overflow_Err),  32'(m_ovf));
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        int          n;
        bit          was_full, do_pop, ovf_evt;
        logic [17:0] e;
        n        = int'(Arith_Valid) + int'(Logic_Valid) + int'(CMP_Valid) + int'(Shift_Valid);
        was_full = (mq.size() == D);
        do_pop   = (mq.size() != 0) && OUT_Ready;
        ovf_evt  = 1'b0;
        if (Arith_Valid)      e = {2'b00, Arith_OUT};
        else if (Logic_Valid) e = {2'b01, Logic_OUT};
        else if (CMP_Valid)   e = {2'b10, CMP_OUT};
        else                  e = {2'b11, Shift_OUT};
        if (do_pop) void'(mq.pop_front());
        if (n == 1) begin
            if (!was_full || do_pop) mq.push_back(e);
            else ovf_evt = 1'b1;
        end
        if (n > 1)        m_coll = 1'b1;
        else if (Err_Clr) m_coll = 1'b0;
        if (ovf_evt)      m_ovf = 1'b1;
        else if (Err_Clr) m_ovf = 1'b0;
    endtask

    // vld bits: [0]=Arith [1]=Logic [2]=CMP [3]=Shift
    task automatic cycle(input logic [3:0] vld, input logic [15:0] d, input logic rdy,
                         input logic clr, input string tag);
        Arith_OUT   = vld[0] ? d : 16'($urandom);
        Logic_OUT   = vld[1] ? d : 16'($urandom);
        CMP_OUT     = vld[2] ? d : 16'($urandom);
        Shift_OUT   = vld[3] ? d : 16'($urandom);
        Arith_Valid = vld[0];
        Logic_Valid = vld[1];
        CMP_Valid   = vld[2];
        Shift_Valid = vld[3];
        OUT_Ready   = rdy;
        Err_Clr     = clr;
        model_step();
        @(posedge CLK);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [3:0] vld;
        RST = 1'b1;
        {Arith_Valid, Logic_Valid, CMP_Valid, Shift_Valid, OUT_Ready, Err_Clr} = '0;
        {Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT} = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_outputs("reset");
        RST = 1'b0;

        // Single encodes, draining between each
        cycle(4'b0001, 16'h00A5, 1'b0, 1'b0, "arith");
        check_eq("arith data", 32'(ALU_OUT), 32'h00A5);
        check_eq("arith code", 32'(ALU_FUN_OUT), 32'h0);
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "drain");
        cycle(4'b0010, 16'h1234, 1'b0, 1'b0, "logic");
        check_eq("logic code", 32'(ALU_FUN_OUT), 32'h1);
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "drain");
        cycle(4'b0100, 16'h0001, 1'b0, 1'b0, "cmp");
        check_eq("cmp code", 32'(ALU_FUN_OUT), 32'h2);
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "drain");
        cycle(4'b1000, 16'h8000, 1'b0, 1'b0, "shift");
        check_eq("shift data", 32'(ALU_OUT), 32'h8000);
        check_eq("shift code", 32'(ALU_FUN_OUT), 32'h3);
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "drain");

        // Fill, backpressure and overflow
        cycle(4'b0100, 16'h0003, 1'b0, 1'b0, "fill1");
        cycle(4'b1000, 16'h0F00, 1'b0, 1'b0, "fill2");
        check_eq("fill busy", 32'(Busy), 32'h1);
        cycle(4'b0010, 16'h00FF, 1'b0, 1'b0, "overflow");
        check_eq("overflow flag", 32'(Overflow_Err), 32'h1);
        check_eq("overflow head", 32'(ALU_OUT), 32'h0003);
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "pop1");
        check_eq("pop1 data", 32'(ALU_OUT), 32'h0F00);
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "pop2");
        check_eq("pop2 empty", 32'(OUT_Valid), 32'h0);
        cycle(4'b0000, 16'h0, 1'b0, 1'b1, "ovf clear");

        // Push and pop together on a full FIFO
        cycle(4'b0001, 16'h1111, 1'b0, 1'b0, "pp fill1");
        cycle(4'b0010, 16'h2222, 1'b0, 1'b0, "pp fill2");
        cycle(4'b0001, 16'h7777, 1'b1, 1'b0, "push+pop");
        check_eq("push+pop busy", 32'(Busy), 32'h1);
        check_eq("push+pop no ovf", 32'(Overflow_Err), 32'h0);
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "pp drain1");
        check_eq("third entry", 32'(ALU_OUT), 32'h7777);
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "pp drain2");

        // Collisions and clear priority
        cycle(4'b0011, 16'h5555, 1'b0, 1'b0, "collision");
        check_eq("collision flag", 32'(Collision_Err), 32'h1);
        check_eq("collision no push", 32'(OUT_Valid), 32'h0);
        cycle(4'b0000, 16'h0, 1'b0, 1'b1, "coll clear");
        check_eq("coll cleared", 32'(Collision_Err), 32'h0);
        cycle(4'b0011, 16'h0, 1'b0, 1'b0, "collision2");
        cycle(4'b0101, 16'h0, 1'b0, 1'b1, "coll set wins");
        check_eq("coll set wins flag", 32'(Collision_Err), 32'h1);
        cycle(4'b0000, 16'h0, 1'b0, 1'b1, "coll clear2");

        // Wrap-around, back-to-back with OUT_Ready always high
        for (int i = 0; i < 6; i++) begin
            vld = 4'b0001 << (i % 4);
            cycle(vld, 16'(i * 16'h1111 + 1), 1'b1, 1'b0, "wrap");
        end
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "wrap end");

        // Asynchronous reset with two entries queued
        cycle(4'b0001, 16'hAAAA, 1'b0, 1'b0, "pre-rst1");
        cycle(4'b0010, 16'hBBBB, 1'b0, 1'b0, "pre-rst2");
        {Arith_Valid, Logic_Valid, CMP_Valid, Shift_Valid, OUT_Ready, Err_Clr} = '0;
        #2 RST = 1'b1;
        #1;
        mq.delete();
        m_coll = 1'b0;
        m_ovf  = 1'b0;
        check_outputs("async reset");
        @(posedge CLK);
        #1 RST = 1'b0;
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "post-rst1");
        cycle(4'b0000, 16'h0, 1'b1, 1'b0, "post-rst2");

        // Randomized traffic; the first half runs with sparse ready to fill up
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2)      vld = 4'b0000;
            else if (r < 8) vld = 4'b0001 << $urandom_range(0, 3);
            else            vld = 4'($urandom_range(0, 15));
            cycle(vld, 16'($urandom),
                  (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 15) == 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_encoder.md
Name: alu_result_encoder

Overview:
Return-path counterpart of the ALU function-select decoder. It collects the four ALU unit results (Arith, Logic, CMP, Shift) with their valid strobes, encodes the active unit back into a 2-bit function code, and queues {code, result} in a small output FIFO. The system controller drains the FIFO through a valid/ready handshake. The block sits between the ALU units and the system controller/UART TX framing.

Parameters:
OUT_WIDTH, 16, width of each unit result and of ALU_OUT
FIFO_DEPTH, 2, number of queued result entries; power of 2, minimum 2

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous reset, active-high
Arith_OUT  input  OUT_WIDTH  arithmetic unit result
Arith_Valid  input  1  arithmetic result strobe, one cycle
Logic_OUT  input  OUT_WIDTH  logic unit result
Logic_Valid  input  1  logic result strobe
CMP_OUT  input  OUT_WIDTH  compare unit result
CMP_Valid  input  1  compare result strobe
Shift_OUT  input  OUT_WIDTH  shift unit result
Shift_Valid  input  1  shift result strobe
OUT_Ready  input  1  consumer accepts the head entry
Err_Clr  input  1  clears the sticky error flags
ALU_OUT  output  OUT_WIDTH  head entry result
ALU_FUN_OUT  output  2  head entry function code
OUT_Valid  output  1  FIFO non-empty
Busy  output  1  FIFO full
Collision_Err  output  1  sticky: more than one unit valid in the same cycle
Overflow_Err  output  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RST). RST high forces all of the following to 0: FIFO read/write pointers, entry count, OUT_Valid, Busy, ALU_OUT, ALU_FUN_OUT, Collision_Err, Overflow_Err.
- Reset mid-operation flushes all queued entries. No entry survives reset.
- Encode, per cycle, from the number of asserted *_Valid:
  - 0 valid: no push.
  - Exactly 1 valid: push {code, data}. Codes: Arith=2'b00, Logic=2'b01, CMP=2'b10, Shift=2'b11.
  - 2 or more valid: no push. Set Collision_Err.
- Push when full without a pop in the same cycle: the entry is dropped and Overflow_Err is set. FIFO contents are unchanged.
- Pop occurs when OUT_Valid && OUT_Ready. The head advances on that clock edge.
- Simultaneous push and pop:
  - When full: both succeed. Count stays at FIFO_DEPTH and no overflow is flagged.
  - When empty: there is no pop, because OUT_Valid=0. The push succeeds.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Latency: a valid input sampled at edge N into an empty FIFO gives OUT_Valid=1 and the head data after edge N (visible in cycle N+1). There is no combinational path from input to output.
- Output register timing:
  - ALU_OUT and ALU_FUN_OUT are registered copies of the head entry.
  - They update in the same cycle that the head changes: after a push into an empty FIFO, or after a pop with entries remaining.
  - When OUT_Valid=0 they read 0.
- OUT_Valid = (count != 0). Busy = (count == FIFO_DEPTH). Both are registered.
- Head data is held stable while OUT_Valid=1 && OUT_Ready=0.
- Sticky flags:
  - Cleared by Err_Clr on the next edge.
  - If a new error event coincides with Err_Clr, the set wins.
  - Err_Clr has no effect on FIFO state.
- OUT_Ready while OUT_Valid=0 is ignored.

Test Plan:
- Reset sweep: assert RST mid-stream with 2 entries queued -> all outputs 0 immediately (asynchronous). After release, OUT_Valid stays 0 until a new strobe.
- Single encode: Arith_Valid=1, Arith_OUT=16'h00A5, OUT_Ready=0 -> one cycle later OUT_Valid=1, ALU_OUT=16'h00A5, ALU_FUN_OUT=2'b00. Repeat for Logic (16'h1234 -> 01), CMP (16'h0001 -> 10), Shift (16'h8000 -> 11), draining between each.
- Fill and backpressure: OUT_Ready=0. Push CMP=16'h0003, then Shift=16'h0F00 -> Busy=1. A third push Logic=16'h00FF -> dropped, Overflow_Err=1. Raise OUT_Ready -> pops 0003/10 then 0F00/11, then OUT_Valid=0.
- Full push+pop: FIFO full, OUT_Ready=1, Arith_Valid=1 with 16'h7777 in the same cycle -> no overflow, Busy stays 1. Order is preserved and 16'h7777/00 emerges third.
- Collision: Arith_Valid=Logic_Valid=1 in one cycle -> no push, OUT_Valid stays 0, Collision_Err=1. Err_Clr alone -> Collision_Err=0 next cycle. Err_Clr coinciding with a new collision -> Collision_Err stays 1.
- Wrap-around: 6 back-to-back single-unit pushes with OUT_Ready=1 every cycle -> 6 outputs in order, each 1 cycle after its push. No errors; pointers wrap without a glitch.
